pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//  Measures an incoming PWM waveform (gate-drive or phase feedback) and recovers its
//  duty cycle in the same DUTY_WIDTH-bit code the phase drivers consume.
//  This is the decode direction of the bldc phase-drive PWM path.
//  Used for closed-loop checks of gate outputs and for reading external PWM command inputs.
//  Handles arbitrary periods via a sequential divider and flags stuck-high/stuck-low lines.
// PARAMETERS
//  DUTY_WIDTH  8     width of recovered duty code; full scale = 2^DUTY_WIDTH-1
//  CNT_WIDTH   16    width of high-time/period counters
//  TIMEOUT     1000  clocks without an edge before declaring the line stuck (< 2^CNT_WIDTH)
// PORTS
//  clock       in   1           system clock; all logic on posedge
//  reset       in   1           asynchronous, active-high reset
//  pwm_in      in   1           asynchronous PWM input
//  duty_cycle  out  DUTY_WIDTH  last recovered duty code
//  period      out  CNT_WIDTH   last measured period in clocks
//  valid       out  1           1-cycle pulse when duty_cycle/period update
//  stuck_high  out  1           line held high >= TIMEOUT clocks
//  stuck_low   out  1           line held low >= TIMEOUT clocks, or no edge since reset
//  overrun     out  1           sticky: rising edge arrived while divider busy
// BEHAVIOUR
//  Reset: duty_cycle=0, period=0, valid=0, stuck_high=0, stuck_low=0, overrun=0.
//   Reset also clears counters, the divider and the state (IDLE).
//   Reset mid-measurement discards the partial result.
//  Input path: 2-flop synchronizer, then a registered copy for edge detect.
//   Edges are seen 3 clocks after the pin changes; all timing below is in synced samples.
//  Counters: hi_cnt counts synced-high clocks, lo_cnt counts synced-low clocks.
//   Both saturate at 2^CNT_WIDTH-1; they never wrap.
//  States:
//   IDLE: wait for first rising edge; hi_cnt=lo_cnt=0.
//    Goes to HIGH on rise.
//    After TIMEOUT clocks with no edge: set stuck_low or stuck_high (per level), go to STUCK.
//   HIGH: hi_cnt++. Falling edge -> LOW.
//    hi_cnt reaches TIMEOUT -> STUCK with stuck_high=1, duty_cycle=all-ones, valid pulse.
//   LOW: lo_cnt++.
//    Rising edge -> capture P=hi_cnt+lo_cnt (saturating) and H=hi_cnt.
//    Start divider, clear counters (count the new period from 1), go to HIGH.
//    lo_cnt reaches TIMEOUT -> STUCK with stuck_low=1, duty_cycle=0, valid pulse.
//   STUCK: hold outputs. Any edge clears both stuck flags.
//    Rise -> HIGH (the first period after STUCK is not divided).
//    Fall -> LOW.
//  Divider: restoring, one quotient bit per clock.
//   Computes Q = floor((H << DUTY_WIDTH) / P), saturated to 2^DUTY_WIDTH-1 (H==P gives all-ones).
//   Starts the cycle after capture and runs DUTY_WIDTH+1 clocks.
//   duty_cycle and period=P update together with a valid pulse DUTY_WIDTH+2 clocks after the capture cycle.
//   Counting continues in parallel with the divider.
//  Simultaneous events:
//   Rising edge while divider busy: sticky overrun=1, capture dropped, in-flight result still completes.
//   Timeout on the same clock as a divider completion: divider result is issued first.
//    The stuck result is issued (second valid pulse) on the next clock.
//  P==0 cannot occur (a period is >=2 samples); the divider is guarded anyway and returns 0.
//  Outputs are registered; the valid pulse is never longer than 1 clock.
// TESTING
//  (DUTY_WIDTH=8, CNT_WIDTH=16, TIMEOUT=1000)
//  1. Period 256 clk, high 64, 5 periods
//      -> from the 2nd rise on, valid each period; duty_cycle=64, period=256.
//  2. Period 200, high 50 -> duty_cycle=64, period=200.
//     Then high 199 of 200 -> duty_cycle=254.
//  3. pwm_in held high 1200 clk after a valid period
//      -> at hi_cnt=1000: stuck_high=1, duty_cycle=255, one valid pulse.
//     A later fall clears stuck_high.
//  4. pwm_in low from reset for 1500 clk -> stuck_low=1 at 1000 clk, duty_cycle=0.
//  5. Period 6 clk, high 3
//      -> overrun latches 1 and stays 1 until reset; no valid pulse longer than 1 clk.
//  6. Assert reset for 1 clk mid-HIGH with divider busy
//      -> all outputs 0 immediately, no valid from the aborted divide.
//     The next full period decodes correctly.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// Recovers duty code and period of an asynchronous PWM input; a sequential restoring
// divider turns high time / period into a DUTY_WIDTH-bit code and flags stuck lines.
module pwm_duty_decoder #(
   parameter int DUTY_WIDTH = 8,
   parameter int CNT_WIDTH  = 16,
   parameter int TIMEOUT    = 1000
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  pwm_i,
   output logic [DUTY_WIDTH-1:0] duty_cycle_o,
   output logic [CNT_WIDTH-1:0]  period_o,
   output logic                  valid_o,
   output logic                  stuck_high_o,
   output logic                  stuck_low_o,
   output logic                  overrun_o
);
   // state | meaning
   // IDLE  | no edge since reset, idle timer running
   // HIGH  | synced line high, hi_cnt counting
   // LOW   | synced line low, lo_cnt counting
   // STUCK | timeout reported, waiting for any edge
   typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

   localparam int STEP_W = $clog2(DUTY_WIDTH + 2);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] TO_M1      = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [STEP_W-1:0]    STEP_FIRST = STEP_W'(DUTY_WIDTH + 1);

   state_t                state_q, state_d;
   logic                  sync1_q, sync2_q, prev_q;
   logic [CNT_WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, idle_q, idle_d;
   logic [CNT_WIDTH:0]    rem_q, rem_d, rem_in, psum;
   logic [CNT_WIDTH-1:0]  div_p_q, div_p_d, p_cap;
   logic [DUTY_WIDTH:0]   quo_q, quo_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic                  busy_q, busy_d;
   logic [DUTY_WIDTH-1:0] duty_q, duty_d, div_res;
   logic [CNT_WIDTH-1:0]  period_q, period_d;
   logic                  valid_q, valid_d, sh_q, sh_d, sl_q, sl_d, ovr_q, ovr_d;
   logic                  pend_q, pend_d, pend_hi_q, pend_hi_d;
   logic                  rise, fall, capture, stuck_evt, stuck_hi, div_done;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   assign rise  = sync2_q & ~prev_q;
   assign fall  = ~sync2_q & prev_q;
   assign psum  = {1'b0, hi_q} + {1'b0, lo_q};
   assign p_cap = psum[CNT_WIDTH] ? CNT_MAX : psum[CNT_WIDTH-1:0];

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      idle_d    = idle_q;
      sh_d      = sh_q;
      sl_d      = sl_q;
      ovr_d     = ovr_q;
      capture   = 1'b0;
      stuck_evt = 1'b0;
      stuck_hi  = 1'b0;
      case (state_q)
         IDLE: begin
            hi_d = '0;
            lo_d = '0;
            if (rise) begin
               hi_d    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               state_d = HIGH;
            end else if (idle_q == '0) begin
               stuck_evt = 1'b1;
               stuck_hi  = sync2_q;
               state_d   = STUCK;
            end else begin
               idle_d = idle_q - 1'b1;
            end
         end
         HIGH: begin
            if (fall) begin
               lo_d    = sat_inc(lo_q);
               state_d = LOW;
            end else if (sync2_q) begin
               hi_d = sat_inc(hi_q);
               if (hi_q == TO_M1) begin
                  stuck_evt = 1'b1;
                  stuck_hi  = 1'b1;
                  state_d   = STUCK;
               end
            end else begin
               lo_d = sat_inc(lo_q);
            end
         end
         LOW: begin
            if (rise) begin
               // hi_q==0 means we entered LOW straight from STUCK: no complete period yet
               if (hi_q != '0) begin
                  if (busy_q) ovr_d = 1'b1;
                  else        capture = 1'b1;
               end
               hi_d    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               lo_d    = '0;
               state_d = HIGH;
            end else begin
               lo_d = sat_inc(lo_q);
               if (lo_q == TO_M1) begin
                  stuck_evt = 1'b1;
                  state_d   = STUCK;
               end
            end
         end
         default: begin
            if (rise || fall) begin
               sh_d = 1'b0;
               sl_d = 1'b0;
               hi_d = rise ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
               lo_d = rise ? '0 : {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               state_d = rise ? HIGH : LOW;
            end
         end
      endcase
      if (stuck_evt) begin
         sh_d = stuck_hi;
         sl_d = ~stuck_hi;
      end
   end

   always_comb begin
      if (div_p_q == '0)          div_res = '0;
      else if (quo_q[DUTY_WIDTH]) div_res = '1;
      else                        div_res = quo_q[DUTY_WIDTH-1:0];
   end

   always_comb begin
      rem_d     = rem_q;
      div_p_d   = div_p_q;
      quo_d     = quo_q;
      step_d    = step_q;
      busy_d    = busy_q;
      duty_d    = duty_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      pend_d    = pend_q;
      pend_hi_d = pend_hi_q;
      div_done  = 1'b0;
      rem_in    = '0;
      if (busy_q) begin
         if (step_q != '0) begin
            // first step tests H against P unshifted to produce the overflow quotient bit
            rem_in = (step_q == STEP_FIRST) ? rem_q : (rem_q << 1);
            if (rem_in >= {1'b0, div_p_q}) begin
               rem_d = rem_in - {1'b0, div_p_q};
               quo_d = {quo_q[DUTY_WIDTH-1:0], 1'b1};
            end else begin
               rem_d = rem_in;
               quo_d = {quo_q[DUTY_WIDTH-1:0], 1'b0};
            end
            step_d = step_q - 1'b1;
         end else begin
            div_done = 1'b1;
            busy_d   = 1'b0;
         end
      end
      if (capture) begin
         rem_d   = {1'b0, hi_q};
         div_p_d = p_cap;
         quo_d   = '0;
         step_d  = STEP_FIRST;
         busy_d  = 1'b1;
      end
      if (div_done) begin
         duty_d   = div_res;
         period_d = div_p_q;
         valid_d  = 1'b1;
         if (stuck_evt) begin
            pend_d    = 1'b1;
            pend_hi_d = stuck_hi;
         end
      end else if (stuck_evt) begin
         duty_d  = {DUTY_WIDTH{stuck_hi}};
         valid_d = 1'b1;
      end else if (pend_q) begin
         duty_d  = {DUTY_WIDTH{pend_hi_q}};
         valid_d = 1'b1;
         pend_d  = 1'b0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
         state_q   <= IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         idle_q    <= TO_M1;
         rem_q     <= '0;
         div_p_q   <= '0;
         quo_q     <= '0;
         step_q    <= '0;
         busy_q    <= 1'b0;
         duty_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         sh_q      <= 1'b0;
         sl_q      <= 1'b0;
         ovr_q     <= 1'b0;
         pend_q    <= 1'b0;
         pend_hi_q <= 1'b0;
      end else begin
         sync1_q   <= pwm_i;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         idle_q    <= idle_d;
         rem_q     <= rem_d;
         div_p_q   <= div_p_d;
         quo_q     <= quo_d;
         step_q    <= step_d;
         busy_q    <= busy_d;
         duty_q    <= duty_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         sh_q      <= sh_d;
         sl_q      <= sl_d;
         ovr_q     <= ovr_d;
         pend_q    <= pend_d;
         pend_hi_q <= pend_hi_d;
      end
   end

   assign duty_cycle_o = duty_q;
   assign period_o     = period_q;
   assign valid_o      = valid_q;
   assign stuck_high_o = sh_q;
   assign stuck_low_o  = sl_q;
   assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: period/duty decode, latency, stuck lines,
// overrun and reset abort, with hand-computed expected values.
module tb_pwm_duty_decoder;
   logic        clk_sys = 1'b0;
   logic        rst     = 1'b1;
   logic        pwm     = 1'b0;
   logic [7:0]  duty_cycle;
   logic [15:0] period;
   logic        valid, stuck_high, stuck_low, overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int vcnt = 0, vrun = 0, vlen_bad = 0;
   int last_duty = 0, last_period = 0;
   int snap, k;

   pwm_duty_decoder #(.DUTY_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT(1000)) dut (
      .clock_i      (clk_sys),
      .reset_i      (rst),
      .pwm_i        (pwm),
      .duty_cycle_o (duty_cycle),
      .period_o     (period),
      .valid_o      (valid),
      .stuck_high_o (stuck_high),
      .stuck_low_o  (stuck_low),
      .overrun_o    (overrun)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      #2;
      if (valid) begin
         vcnt++;
         last_duty   = int'(duty_cycle);
         last_period = int'(period);
         vrun++;
         if (vrun > 1) vlen_bad++;
      end else begin
         vrun = 0;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pwm = 1'b0;
      repeat (2) @(negedge clk_sys);
      rst = 1'b0;
   endtask

   task automatic run_pwm(input int hi, input int per, input int n);
      for (int i = 0; i < n; i++) begin
         pwm = 1'b1;
         repeat (hi) @(negedge clk_sys);
         pwm = 1'b0;
         repeat (per - hi) @(negedge clk_sys);
      end
   endtask

   task automatic wait_flag(input int which, input int limit, output int cycles);
      cycles = limit;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk_sys);
         if ((which == 0 && valid) || (which == 1 && stuck_high) || (which == 2 && stuck_low)) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      @(negedge clk_sys);
      do_reset();
      @(negedge clk_sys);
      check_eq("rst_duty", int'(duty_cycle), 0);
      check_eq("rst_period", int'(period), 0);
      check_eq("rst_valid", int'(valid), 0);
      check_eq("rst_stuck_high", int'(stuck_high), 0);
      check_eq("rst_stuck_low", int'(stuck_low), 0);
      check_eq("rst_overrun", int'(overrun), 0);

      // 64/256 x5, trailing rise; result lands 13 clocks after the pin rises
      snap = vcnt;
      run_pwm(64, 256, 5);
      pwm = 1'b1;
      wait_flag(0, 40, k);
      check_eq("t1_latency", k, 13);
      repeat (3) @(negedge clk_sys);
      check_eq("t1_valid_count", vcnt - snap, 5);
      check_eq("t1_duty", last_duty, 64);
      check_eq("t1_period", last_period, 256);
      check_eq("t1_overrun", int'(overrun), 0);

      // 50/200 -> 64, then 199/200 -> floor(199*256/200)=254
      do_reset();
      run_pwm(50, 200, 3);
      pwm = 1'b1;
      repeat (20) @(negedge clk_sys);
      check_eq("t2_duty_a", last_duty, 64);
      check_eq("t2_period_a", last_period, 200);
      repeat (179) @(negedge clk_sys);
      pwm = 1'b0;
      @(negedge clk_sys);
      run_pwm(199, 200, 2);
      pwm = 1'b1;
      repeat (20) @(negedge clk_sys);
      check_eq("t2_duty_b", last_duty, 254);
      check_eq("t2_period_b", last_period, 200);

      // held high: hi_cnt hits 1000 at the 1002nd clock after the pin rise
      do_reset();
      run_pwm(64, 256, 2);
      snap = vcnt;
      pwm = 1'b1;
      wait_flag(1, 1100, k);
      check_eq("t3_stuck_time", k, 1002);
      check_eq("t3_duty", int'(duty_cycle), 255);
      check_eq("t3_valid_count", vcnt - snap, 2);
      repeat (1200 - 1002) @(negedge clk_sys);
      pwm = 1'b0;
      repeat (6) @(negedge clk_sys);
      check_eq("t3_stuck_high_clr", int'(stuck_high), 0);
      check_eq("t3_stuck_low_clr", int'(stuck_low), 0);

      // low from reset
      do_reset();
      wait_flag(2, 1100, k);
      check_eq("t4_stuck_time", k, 1000);
      check_eq("t4_duty", int'(duty_cycle), 0);
      check_eq("t4_stuck_high", int'(stuck_high), 0);
      repeat (500) @(negedge clk_sys);
      check_eq("t4_stuck_low_hold", int'(stuck_low), 1);

      // period 6 is shorter than the divide: overrun must latch
      do_reset();
      snap = vcnt;
      run_pwm(3, 6, 20);
      check_eq("t5_overrun", int'(overrun), 1);
      check_eq("t5_valid_seen", int'(vcnt > snap), 1);
      repeat (50) @(negedge clk_sys);
      check_eq("t5_overrun_sticky", int'(overrun), 1);

      // reset while divider busy
      do_reset();
      run_pwm(64, 256, 2);
      pwm = 1'b1;
      repeat (6) @(negedge clk_sys);
      rst = 1'b1;
      #1;
      check_eq("t6_duty", int'(duty_cycle), 0);
      check_eq("t6_period", int'(period), 0);
      check_eq("t6_valid", int'(valid), 0);
      check_eq("t6_overrun", int'(overrun), 0);
      check_eq("t6_stuck", int'(stuck_high | stuck_low), 0);
      @(negedge clk_sys);
      rst = 1'b0;
      snap = vcnt;
      repeat (20) @(negedge clk_sys);
      check_eq("t6_no_stale_valid", vcnt - snap, 0);
      pwm = 1'b0;
      repeat (192) @(negedge clk_sys);
      run_pwm(64, 256, 1);
      pwm = 1'b1;
      repeat (20) @(negedge clk_sys);
      check_eq("t6_duty_after", last_duty, 64);
      check_eq("t6_period_after", last_period, 256);

      check_eq("valid_pulse_len", vlen_bad, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
